sa_load_sequencer: RTL and testbench

//  Sequencer for Top_SA_Data_Loader. On one start pulse it runs the full 3x3 convolution schedule.
//  - Weight preload once (mode=0).
//  - Feature load (mode=1) once per output pixel, walking a 2-D window of feature base addresses.

---
 rtl/sa_load_sequencer_pkg.sv | 33 +++
 rtl/sa_load_sequencer_if.sv | 31 +++
 rtl/sa_load_sequencer_addr_gen.sv | 53 +++++
 rtl/sa_load_sequencer.sv | 129 ++++++++++++
 tb/tb_sa_load_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_load_sequencer_pkg.sv
// Shared constants for the SA load sequencer: state encoding, default geometry,
// and the window base-address arithmetic.
package sa_load_sequencer_pkg;

  localparam int ADDR_W_DEFAULT    = 6;
  localparam int IMG_W_DEFAULT     = 8;
  localparam int OUT_W_DEFAULT     = 6;
  localparam int OUT_H_DEFAULT     = 6;
  localparam int FEAT_BASE_DEFAULT = 0;
  localparam int WCNT_W            = 12;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_FLOAD = 3'd2;
  localparam logic [2:0] S_FGAP  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_WLOAD = S_WLOAD,
    ST_FLOAD = S_FLOAD,
    ST_FGAP  = S_FGAP,
    ST_FIN   = S_FIN
  } state_e;

  // Full-width address; callers truncate, so the window wraps modulo 2^ADDR_W.
  function automatic logic [31:0] win_addr(input int base, input int pitch,
                                           input logic [WCNT_W-1:0] row,
                                           input logic [WCNT_W-1:0] col);
    return 32'(base) + 32'(row) * 32'(pitch) + 32'(col);
  endfunction

endpackage

// File: rtl/sa_load_sequencer_if.sv
// Control/handshake bundle between the top-level FSM, the sequencer and the data loader.
// master = sequencer side, slave = controller/loader side.
interface sa_load_sequencer_if
  import sa_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);
  logic              start;
  logic              abort;
  logic              is_WL_done_i;
  logic              is_FL_done_i;
  logic              Weight_Preloader_en;
  logic              Feature_Loader_en;
  logic              mode;
  logic [ADDR_W-1:0] feature_baseaddr;
  logic              busy;
  logic              done;
  logic [WCNT_W-1:0] win_cnt;

  modport master (
    input  start, abort, is_WL_done_i, is_FL_done_i,
    output Weight_Preloader_en, Feature_Loader_en, mode, feature_baseaddr,
           busy, done, win_cnt
  );

  modport slave (
    output start, abort, is_WL_done_i, is_FL_done_i,
    input  Weight_Preloader_en, Feature_Loader_en, mode, feature_baseaddr,
           busy, done, win_cnt
  );
endinterface

// File: rtl/sa_load_sequencer_addr_gen.sv
// Row/column walker over the output window grid; addr_o is the base address of
// the current (row, col) window, last_o flags the final window.
module sa_window_addr_gen
  import sa_load_sequencer_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int IMG_W     = IMG_W_DEFAULT,
  parameter int OUT_W     = OUT_W_DEFAULT,
  parameter int OUT_H     = OUT_H_DEFAULT,
  parameter int FEAT_BASE = FEAT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic [WCNT_W-1:0] row_q, row_d;
  logic [WCNT_W-1:0] col_q, col_d;
  logic [31:0]       addr_full;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q < WCNT_W'(OUT_W - 1)) begin
        col_d = col_q + 12'd1;
      end else begin
        col_d = '0;
        row_d = row_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign addr_full = win_addr(FEAT_BASE, IMG_W, row_q, col_q);
  assign addr_o    = addr_full[ADDR_W-1:0];
  assign last_o    = (col_q == WCNT_W'(OUT_W - 1)) && (row_q == WCNT_W'(OUT_H - 1));

endmodule

// File: rtl/sa_load_sequencer.sv
// Runs one weight preload then one feature load per output window on each start;
// all outputs registered, abort/rst return to IDLE on the next edge.
module sa_load_sequencer
  import sa_load_sequencer_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int IMG_W     = IMG_W_DEFAULT,
  parameter int OUT_W     = OUT_W_DEFAULT,
  parameter int OUT_H     = OUT_H_DEFAULT,
  parameter int FEAT_BASE = FEAT_BASE_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  sa_load_sequencer_if.master bus
);
  state_e            state_q, state_d;
  logic              wl_en_q, wl_en_d;
  logic              fl_en_q, fl_en_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
  logic              addr_clr, addr_adv, addr_last;
  logic [ADDR_W-1:0] gen_addr;

  sa_window_addr_gen #(
    .ADDR_W   (ADDR_W),
    .IMG_W    (IMG_W),
    .OUT_W    (OUT_W),
    .OUT_H    (OUT_H),
    .FEAT_BASE(FEAT_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (addr_clr),
    .advance_i(addr_adv),
    .addr_o   (gen_addr),
    .last_o   (addr_last)
  );

  always_comb begin
    state_d   = state_q;
    wl_en_d   = wl_en_q;
    fl_en_d   = fl_en_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    win_cnt_d = win_cnt_q;
    addr_clr  = 1'b0;
    addr_adv  = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
      wl_en_d = 1'b0;
      fl_en_d = 1'b0;
      mode_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          state_d   = ST_WLOAD;
          wl_en_d   = 1'b1;
          mode_d    = 1'b0;
          addr_clr  = 1'b1;
          win_cnt_d = '0;
        end
        ST_WLOAD: if (bus.is_WL_done_i) begin
          state_d = ST_FLOAD;
          wl_en_d = 1'b0;
          mode_d  = 1'b1;
          fl_en_d = 1'b1;
          addr_d  = ADDR_W'(FEAT_BASE);
        end
        ST_FLOAD: if (bus.is_FL_done_i) begin
          win_cnt_d = win_cnt_q + 12'd1;
          fl_en_d   = 1'b0;
          if (addr_last) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            // Step the walker now so the next address is ready during the gap cycle.
            state_d  = ST_FGAP;
            addr_adv = 1'b1;
          end
        end
        ST_FGAP: begin
          state_d = ST_FLOAD;
          fl_en_d = 1'b1;
          addr_d  = gen_addr;
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          mode_d  = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wl_en_q   <= 1'b0;
      fl_en_q   <= 1'b0;
      mode_q    <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wl_en_q   <= wl_en_d;
      fl_en_q   <= fl_en_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign bus.Weight_Preloader_en = wl_en_q;
  assign bus.Feature_Loader_en   = fl_en_q;
  assign bus.mode                = mode_q;
  assign bus.feature_baseaddr    = addr_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.win_cnt             = win_cnt_q;

endmodule

// File: tb/tb_sa_load_sequencer.sv
// Bench for sa_load_sequencer: two geometries, a latency-programmable loader model,
// and an expected-address list built from the window grid.
module tb_sa_load_sequencer;
  typedef logic [5:0] aq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_load_sequencer_if #(.ADDR_W(6)) ifa ();
  sa_load_sequencer_if #(.ADDR_W(6)) ifb ();

  sa_load_sequencer #(.ADDR_W(6), .IMG_W(5), .OUT_W(3), .OUT_H(3), .FEAT_BASE(9)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  sa_load_sequencer #(.ADDR_W(6), .IMG_W(5), .OUT_W(2), .OUT_H(2), .FEAT_BASE(60)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;

  // Loader model: done pulses after a programmable number of enabled cycles.
  int   wl_lat_a = 4, fl_lat_a = 6, wl_c_a = 0, fl_c_a = 0, wl_c_b = 0, fl_c_b = 0;
  logic ld_wl_a = 1'b0, ld_fl_a = 1'b0, frc_fl_a = 1'b0, ld_wl_b = 1'b0, ld_fl_b = 1'b0;
  assign ifa.is_WL_done_i = ld_wl_a;
  assign ifa.is_FL_done_i = ld_fl_a | frc_fl_a;
  assign ifb.is_WL_done_i = ld_wl_b;
  assign ifb.is_FL_done_i = ld_fl_b;

  always @(negedge clk) begin
    if (ifa.Weight_Preloader_en) begin wl_c_a++; ld_wl_a = (wl_c_a == wl_lat_a); end
    else begin wl_c_a = 0; ld_wl_a = 1'b0; end
    if (ifa.Feature_Loader_en) begin fl_c_a++; ld_fl_a = (fl_c_a == fl_lat_a); end
    else begin fl_c_a = 0; ld_fl_a = 1'b0; end
    if (ifb.Weight_Preloader_en) begin wl_c_b++; ld_wl_b = (wl_c_b == 2); end
    else begin wl_c_b = 0; ld_wl_b = 1'b0; end
    if (ifb.Feature_Loader_en) begin fl_c_b++; ld_fl_b = (fl_c_b == 3); end
    else begin fl_c_b = 0; ld_fl_b = 1'b0; end
  end

  // Observation of window starts, gap widths, address stability and done/busy relation.
  aq_t  addr_q_a, addr_q_b;
  int   cyc = 0, fall_cyc_a = 0, done_cnt_a = 0, done_cnt_b = 0;
  int   gap_bad = 0, stab_bad = 0, mode_bad = 0, busy_bad = 0;
  logic fl_prev_a = 1'b0, fl_prev_b = 1'b0, mode_prev_a = 1'b0, done_prev_a = 1'b0;
  logic [5:0] addr_prev_a = '0;

  always @(negedge clk) begin
    cyc++;
    if (ifa.Feature_Loader_en && !fl_prev_a) begin
      if (addr_q_a.size() == 0) begin
        if (!(ifa.mode === 1'b1 && mode_prev_a === 1'b0)) mode_bad++;
      end else if (cyc - fall_cyc_a != 1) gap_bad++;
      addr_q_a.push_back(ifa.feature_baseaddr);
    end
    if (ifa.Feature_Loader_en && fl_prev_a && ifa.feature_baseaddr !== addr_prev_a) stab_bad++;
    if (!ifa.Feature_Loader_en && fl_prev_a) fall_cyc_a = cyc;
    if (ifa.done) begin done_cnt_a++; if (!ifa.busy) busy_bad++; end
    if (done_prev_a && ifa.busy) busy_bad++;
    fl_prev_a   = ifa.Feature_Loader_en;
    mode_prev_a = ifa.mode;
    done_prev_a = ifa.done;
    addr_prev_a = ifa.feature_baseaddr;
    if (ifb.Feature_Loader_en && !fl_prev_b) addr_q_b.push_back(ifb.feature_baseaddr);
    if (ifb.done) done_cnt_b++;
    fl_prev_b = ifb.Feature_Loader_en;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic aq_t model(input int base, input int imgw, input int ow, input int oh);
    aq_t q;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++)
        q.push_back(6'((base + r * imgw + c) % 64));
    return q;
  endfunction

  task automatic cmp_addrs(input string tag, input aq_t got, input aq_t exp);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic clear_a();
    addr_q_a.delete();
    done_cnt_a = 0;
  endtask

  task automatic start_a();
    ifa.start = 1'b1; step(); ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    logic hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step();
      if (ifa.done === 1'b1) hit = 1'b1;
    end
    chk(tag, 32'(hit), 1);
  endtask

  task automatic wait_rises_a(input string tag, input int n);
    logic hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step();
      if (addr_q_a.size() >= n) hit = 1'b1;
    end
    chk(tag, 32'(hit), 1);
  endtask

  task automatic chk_idle_a(input string tag, input int exp_cnt);
    chk({tag, "_wl_en"}, 32'(ifa.Weight_Preloader_en), 0);
    chk({tag, "_fl_en"}, 32'(ifa.Feature_Loader_en), 0);
    chk({tag, "_mode"},  32'(ifa.mode), 0);
    chk({tag, "_busy"},  32'(ifa.busy), 0);
    chk({tag, "_done"},  32'(ifa.done), 0);
    chk({tag, "_win_cnt"}, 32'(ifa.win_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    aq_t exp_a;
    exp_a = model(9, 5, 3, 3);
    rst = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    step(3);
    chk_idle_a("reset", 0);
    chk("reset_addr", 32'(ifa.feature_baseaddr), 0);
    rst = 1'b0;
    step(2);

    // Full run with 4-cycle preload and 6-cycle windows.
    clear_a(); wl_lat_a = 4; fl_lat_a = 6;
    ifa.start = 1'b1;
    chk("wl_en_before_edge", 32'(ifa.Weight_Preloader_en), 0);
    step(); ifa.start = 1'b0;
    chk("wl_en_one_cycle", 32'(ifa.Weight_Preloader_en), 1);
    chk("busy_after_start", 32'(ifa.busy), 1);
    chk("mode_in_wload", 32'(ifa.mode), 0);
    wait_done_a("run1_done_seen");
    chk("run1_win_cnt", 32'(ifa.win_cnt), 9);
    chk("run1_busy_at_done", 32'(ifa.busy), 1);
    step();
    chk_idle_a("run1_after", 9);
    cmp_addrs("run1_addr", addr_q_a, exp_a);
    chk("run1_done_pulses", 32'(done_cnt_a), 1);
    step(3);
    chk("run1_win_cnt_hold", 32'(ifa.win_cnt), 9);

    // Wrapping geometry on the second instance.
    ifb.start = 1'b1; step(); ifb.start = 1'b0;
    begin
      logic hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin step(); if (ifb.done === 1'b1) hit = 1'b1; end
      chk("wrap_done_seen", 32'(hit), 1);
    end
    chk("wrap_win_cnt", 32'(ifb.win_cnt), 4);
    step();
    chk("wrap_busy_after", 32'(ifb.busy), 0);
    cmp_addrs("wrap_addr", addr_q_b, model(60, 5, 2, 2));
    chk("wrap_done_pulses", 32'(done_cnt_b), 1);

    // Feature-done during preload and start during feature load are ignored.
    clear_a(); wl_lat_a = 8; fl_lat_a = $urandom_range(1, 7);
    start_a(); step();
    frc_fl_a = 1'b1; step(2); frc_fl_a = 1'b0;
    chk("spur_fl_wl_en", 32'(ifa.Weight_Preloader_en), 1);
    chk("spur_fl_fl_en", 32'(ifa.Feature_Loader_en), 0);
    chk("spur_fl_win_cnt", 32'(ifa.win_cnt), 0);
    wait_rises_a("spur_rises_seen", 2);
    ifa.start = 1'b1; step(); ifa.start = 1'b0;
    chk("spur_start_wl_en", 32'(ifa.Weight_Preloader_en), 0);
    chk("spur_start_mode", 32'(ifa.mode), 1);
    chk("spur_start_busy", 32'(ifa.busy), 1);
    wait_done_a("spur_done_seen");
    chk("spur_win_cnt", 32'(ifa.win_cnt), 9);
    step();
    cmp_addrs("spur_addr", addr_q_a, exp_a);
    chk("spur_done_pulses", 32'(done_cnt_a), 1);

    // Randomised loader latencies.
    for (int r = 0; r < 3; r++) begin
      clear_a(); wl_lat_a = $urandom_range(1, 6); fl_lat_a = $urandom_range(1, 8);
      start_a();
      wait_done_a($sformatf("rnd%0d_done_seen", r));
      chk($sformatf("rnd%0d_win_cnt", r), 32'(ifa.win_cnt), 9);
      step();
      cmp_addrs($sformatf("rnd%0d_addr", r), addr_q_a, exp_a);
      chk($sformatf("rnd%0d_done_pulses", r), 32'(done_cnt_a), 1);
    end

    // Abort during the 4th feature window, then restart.
    clear_a(); wl_lat_a = 3; fl_lat_a = 6;
    start_a();
    wait_rises_a("abort_rises_seen", 4);
    ifa.abort = 1'b1; step(); ifa.abort = 1'b0;
    chk_idle_a("abort", 3);
    step(4);
    chk("abort_win_cnt_hold", 32'(ifa.win_cnt), 3);
    chk("abort_no_done", 32'(done_cnt_a), 0);
    clear_a();
    start_a();
    chk("restart_wl_en", 32'(ifa.Weight_Preloader_en), 1);
    chk("restart_mode", 32'(ifa.mode), 0);
    chk("restart_win_cnt", 32'(ifa.win_cnt), 0);
    wait_done_a("restart_done_seen");
    chk("restart_win_cnt_end", 32'(ifa.win_cnt), 9);
    step();
    cmp_addrs("restart_addr", addr_q_a, exp_a);

    // start and abort together in IDLE.
    ifa.start = 1'b1; ifa.abort = 1'b1; step();
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("start_abort_busy", 32'(ifa.busy), 0);
    chk("start_abort_wl_en", 32'(ifa.Weight_Preloader_en), 0);
    step();
    chk("start_abort_busy_later", 32'(ifa.busy), 0);

    // Synchronous reset mid-run.
    clear_a(); wl_lat_a = 2; fl_lat_a = 5;
    start_a();
    wait_rises_a("rst_rises_seen", 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk_idle_a("midrst", 0);
    chk("midrst_addr", 32'(ifa.feature_baseaddr), 0);
    step(2);
    chk("midrst_stays_idle", 32'(ifa.busy), 0);

    chk("fl_gap_one_cycle", 32'(gap_bad), 0);
    chk("addr_stable_in_fload", 32'(stab_bad), 0);
    chk("mode_rises_with_fl_en", 32'(mode_bad), 0);
    chk("busy_vs_done", 32'(busy_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
